// File: rtl/request_queue_manager.sv
// Four saturating per-queue job counters feeding a round-robin arbiter.
// Pushes arrive as asynchronous button levels; pops happen after a full service period of stable grant.
module request_queue_manager #(
    parameter int CNT_W          = 3,
    parameter int SERVICE_CYCLES = 150000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         push,
    input  logic [3:0]         grant_in,
    output logic [3:0]         request_queue,
    output logic [4*CNT_W-1:0] occupancy,
    output logic [3:0]         queue_full,
    output logic [3:0]         overflow,
    output logic [3:0]         served
);

    localparam int TMR_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SERVICE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [3:0]       s1_reg, s2_reg, s3_reg;
    logic [3:0]       grant_q_reg;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             grant_onehot, grant_stable, service;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= push;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign grant_onehot = $onehot(grant_in);
    assign grant_stable = (grant_in == grant_q_reg);
    assign service      = grant_onehot && grant_stable && (timer_reg == TMR_LAST);

    // Any grant glitch or change discards the partial slice.
    always_comb begin
        timer_next = timer_reg + TMR_W'(1);
        if (!grant_onehot || !grant_stable || service) begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg   <= '0;
            grant_q_reg <= '0;
        end else begin
            timer_reg   <= timer_next;
            grant_q_reg <= grant_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_queue
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             ovf_reg, served_reg;
            logic             full, empty, push_ev, pop_ev;

            assign full    = (cnt_reg == CNT_MAX);
            assign empty   = (cnt_reg == '0);
            assign push_ev = s2_reg[gi] & ~s3_reg[gi];
            assign pop_ev  = service & grant_in[gi] & ~empty;

            // Push together with pop leaves the count alone, even when full.
            always_comb begin
                cnt_next = cnt_reg;
                if (push_ev && !pop_ev && !full) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (pop_ev && !push_ev) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    ovf_reg    <= 1'b0;
                    served_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    served_reg <= pop_ev;
                    if (push_ev && full && !pop_ev) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end

            assign occupancy[gi*CNT_W +: CNT_W] = cnt_reg;
            assign request_queue[gi]            = ~empty;
            assign queue_full[gi]               = full;
            assign overflow[gi]                 = ovf_reg;
            assign served[gi]                   = served_reg;
        end
    endgenerate

endmodule

// File: doc/request_queue_manager.md
# request_queue_manager

Front-end stage that feeds the round-robin arbiter's `request_queue` input. It keeps four per-queue occupancy counters. Counters are filled by push pulses (synchronised board buttons). Counters are drained one entry at a time while the arbiter's grant for that queue is held for a full service period. `request_queue[i]` is high whenever queue i holds at least one pending job, so the arbiter returns to IDLE only when all counters are empty.

## Interface
- `CNT_W`, default 3: occupancy counter width; capacity per queue is 2^CNT_W − 1 (7).
- `SERVICE_CYCLES`, default 150000000: clock cycles of continuous grant needed to serve (pop) one entry; 3 s at 50 MHz.
- `clk`  in  1: single system clock; all state is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset; clears all state immediately.
- `push`  in  4: asynchronous level inputs, one per queue; each rising edge is one job.
- `grant_in`  in  4: one-hot grant from the arbiter; `4'b0000` means idle.
- `request_queue`  out  4: bit i = (occupancy of queue i != 0); goes to the arbiter.
- `occupancy`  out  4*CNT_W: counters packed with queue i at bits [i*CNT_W +: CNT_W].
- `queue_full`  out  4: bit i = occupancy of queue i equals 2^CNT_W − 1.
- `overflow`  out  4: sticky; set when a push arrives at a full queue.
- `served`  out  4: one-cycle pulse on the pop of queue i.

## Operation
- **Input synchroniser:** each `push` bit passes through a 2-flop synchroniser (s1, s2) and then a third flop (s3). The push event is s2 & ~s3. Only one event occurs per rising edge, however long the button is held.
- **Service timer:** width is `$clog2(SERVICE_CYCLES)`. A registered copy `grant_q` holds the previous cycle's `grant_in`.
  - Timer clears to 0 when `grant_in` is not exactly one-hot (zero or multi-hot).
  - Timer clears to 0 when `grant_in != grant_q` (grant changed).
  - Otherwise the timer increments.
  - When the timer equals `SERVICE_CYCLES − 1`, the cycle is a service cycle. On the next edge the timer wraps to 0 and the granted queue pops.
- **Pop:** applies to the queue selected by one-hot `grant_in`. It decrements occupancy and pulses `served[i]` for one cycle. A pop on an empty queue is ignored: no decrement and no `served` pulse.
- **Push:** increments occupancy. A push on a full queue is dropped, the counter is unchanged, and `overflow[i]` is set. `overflow` clears only on reset.
- **Simultaneous push and pop on the same queue:**
  - Occupancy is unchanged and `served` pulses.
  - If the queue is full, the push is accepted: the pop frees the slot, so no overflow is raised.
  - If the queue is empty, the push is accepted, the pop is ignored, and the count becomes 1.
- **Queue independence:** queues are independent. Pushes on all four queues in the same cycle are all applied.
- **Combinational outputs:** `request_queue` and `queue_full` are decoded directly from the counters. Arithmetic never wraps: saturation is enforced by the full/empty checks above.

## Timing
- **Reset values:** reset low clears everything asynchronously. Counters, timer, `grant_q`, and synchroniser flops go to 0. `request_queue`, `occupancy`, `queue_full`, `overflow`, and `served` are all 0 and remain 0 while reset is low.
- **Push latency:**
  - `push[i]` rising before edge E1 is captured in s1 at E1 and s2 at E2.
  - The event is true during the cycle after E2, and occupancy increments at E3.
  - `request_queue[i]` is high after E3. Total latency: 3 edges.
- **Service latency:** with a stable one-hot grant first sampled at edge G0, the timer is 0 after G0. Pops occur at edges G0+SERVICE_CYCLES, G0+2·SERVICE_CYCLES, and so on. `served[i]` is high for the cycle following each pop edge.
- **Grant change mid-slice:** the partial count is discarded and the new queue needs a full `SERVICE_CYCLES` of grant.
- **Drain to empty:** after the last entry of the only non-empty queue pops, `request_queue` drops to 0 in the same cycle the counter reaches 0.
- **Reset mid-operation:** pending counts are lost. After reset is released, the first push needs 3 edges to reach the counters.

## Test plan
Scenarios 4–6 use `SERVICE_CYCLES`=4.
1. **Reset:** hold reset low, toggle `push` and `grant_in` → all outputs 0; after release with idle inputs, outputs remain 0.
2. **Push latency and edge detection:** three separate rising edges on `push[0]`, each held high 10 cycles → occupancy q0 = 3, `request_queue`=0001, each increment 3 edges after its rising edge.
3. **Overflow:** 8 edges on `push[2]` → q2 = 7, `queue_full`=0100, `overflow`=0100 (set on the 8th edge, still set after later pops).
4. **Service period:** q2 = 7 and `grant_in`=0100 held → `served[2]` pulses every 4 cycles and q2 counts 6,5,…,0; then `request_queue[2]`=0 and no further pulses. `grant_in`=0000 → timer stays 0.
5. **Simultaneous push and pop:**
   - q1 = 2, push event coincident with a service cycle on queue 1 → q1 stays 2 and `served[1]` pulses.
   - q1 = 7, same coincidence → q1 = 7 and `overflow[1]` stays 0.
6. **Grant change and reset mid-slice:**
   - `grant_in` 0001 for 3 cycles, then 0010 → no pop on q0; first pop of q1 occurs 4 cycles after the change.
   - Assert reset while q0 = 5 → everything 0 immediately, with no clock edge required.
